// File: rtl/zx_fdd_mailbox_ctrl.sv
// ---------------------------------------------------------------------------
// zx_fdd_mailbox_ctrl
//   Handshake sequencer for the two 6-bit ZX<->FDD mailbox latches.
//   Channel A carries bytes ZX -> FDD, channel B carries bytes FDD -> ZX.
//   The four asynchronous, active-low CPU strobes are synchronised into
//   CLK_16MHZ. A transfer completes when its strobe is deasserted.
//   Each channel tracks FULL/EMPTY, pulses its latch enable once per write,
//   and records overruns (write while FULL) in a sticky flag and a
//   saturating counter.
//
//   Optional feature macro: MAILBOX_TIMEOUT_EN
//     When defined, a mailbox left FULL for TIMEOUT_CYCLES cycles is forced
//     EMPTY and its sticky TMO flag is set. When undefined, A_TMO/B_TMO
//     are tied 0.
//
// Parameters
//   SYNC_STAGES     synchroniser depth per strobe (>= 2)
//   OVR_CNT_W       width of each saturating overrun counter
//   TIMEOUT_CYCLES  FULL residency limit (MAILBOX_TIMEOUT_EN only)
//
// Ports
//   CLK_16MHZ      master clock
//   nRESET         synchronous active-low reset
//   nZX_WR_STB     ZX write strobe (channel A write), async, active low
//   nZX_RD_STB     ZX read strobe  (channel B read),  async, active low
//   nTIOUT         FDD write strobe (channel B write), async, active low
//   nTIIN          FDD read strobe  (channel A read),  async, active low
//   ERR_CLR        one-cycle pulse: clear OVR, OVR_CNT and TMO
//   ZX_LATCH_EN    1-cycle capture pulse for the zx->fdd latch
//   FDD_LATCH_EN   1-cycle capture pulse for the fdd->zx latch
//   A_FULL/B_FULL  mailbox holds an unread byte
//   A_OVR/B_OVR    sticky overrun flags
//   A_OVR_CNT/B_OVR_CNT  saturating overrun counters
//   A_TMO/B_TMO    sticky timeout flags
// ---------------------------------------------------------------------------
module zx_fdd_mailbox_ctrl #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned OVR_CNT_W      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 CLK_16MHZ,
  input  logic                 nRESET,
  input  logic                 nZX_WR_STB,
  input  logic                 nZX_RD_STB,
  input  logic                 nTIOUT,
  input  logic                 nTIIN,
  input  logic                 ERR_CLR,
  output logic                 ZX_LATCH_EN,
  output logic                 FDD_LATCH_EN,
  output logic                 A_FULL,
  output logic                 B_FULL,
  output logic                 A_OVR,
  output logic                 B_OVR,
  output logic [OVR_CNT_W-1:0] A_OVR_CNT,
  output logic [OVR_CNT_W-1:0] B_OVR_CNT,
  output logic                 A_TMO,
  output logic                 B_TMO
);

  typedef enum logic {
    MB_EMPTY = 1'b0,
    MB_FULL  = 1'b1
  } mb_state_t;

  if (SYNC_STAGES < 2 || OVR_CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("zx_fdd_mailbox_ctrl: invalid parameter value");
  end

`ifdef MAILBOX_TIMEOUT_EN
  localparam int unsigned          TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

  // Strobe order is {ch B read, ch B write, ch A read, ch A write} so that
  // channel c uses done[2c] as its write and done[2c+1] as its read.
  logic [3:0] strobe_n;
  logic [3:0] done;

  assign strobe_n = {nZX_RD_STB, nTIOUT, nTIIN, nZX_WR_STB};

  for (genvar g = 0; g < 4; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Reset loads the inactive level so a strobe held low across reset
    // release produces no event until it is finally deasserted.
    always_ff @(posedge CLK_16MHZ) begin
      if (!nRESET) begin
        sync_q <= '1;
        edge_q <= 1'b1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n[g]};
        edge_q <= sync_q[SYNC_STAGES-1];
      end
    end

    // Completion = synchronised 0->1 transition (strobe deassert).
    assign done[g] = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  logic [1:0]                latch_v;
  logic [1:0]                full_v;
  logic [1:0]                ovr_v;
  logic [1:0]                tmo_v;
  logic [1:0][OVR_CNT_W-1:0] cnt_v;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic                 wr_done;
    logic                 rd_done;
    logic                 latch_q;
    logic                 rd_q;
    mb_state_t            state_q;
    mb_state_t            state_d;
    logic                 ovr_q;
    logic                 ovr_d;
    logic                 tmo_q;
    logic                 tmo_d;
    logic [OVR_CNT_W-1:0] cnt_q;
    logic [OVR_CNT_W-1:0] cnt_d;
    logic                 ovr_evt;
    logic                 tmo_evt;
    logic                 tmo_hit;

    assign wr_done = done[2*c];
    assign rd_done = done[2*c+1];

`ifdef MAILBOX_TIMEOUT_EN
    logic [TMO_W-1:0] tcnt_q;
    logic [TMO_W-1:0] tcnt_d;

    assign tmo_hit = (state_q == MB_FULL) && (tcnt_q == TMO_LAST);

    // Counts only while the mailbox stays FULL with no new write; any
    // write (including the one that fills it) restarts the count.
    always_comb begin
      tcnt_d = '0;
      if (state_q == MB_FULL && state_d == MB_FULL && !latch_q) begin
        tcnt_d = tcnt_q + TMO_W'(1);
      end
    end

    always_ff @(posedge CLK_16MHZ) begin
      if (!nRESET) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_d;
      end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // The latch pulse and the registered read event are consumed by the
    // state logic one cycle later, so FULL follows the latch pulse.
    always_ff @(posedge CLK_16MHZ) begin
      if (!nRESET) begin
        latch_q <= 1'b0;
        rd_q    <= 1'b0;
        state_q <= MB_EMPTY;
        ovr_q   <= 1'b0;
        tmo_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        latch_q <= wr_done;
        rd_q    <= rd_done;
        state_q <= state_d;
        ovr_q   <= ovr_d;
        tmo_q   <= tmo_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      ovr_evt = 1'b0;
      tmo_evt = 1'b0;
      unique case (state_q)
        MB_EMPTY: begin
          // A read with nothing stored is ignored, even alongside a write.
          if (latch_q) begin
            state_d = MB_FULL;
          end
        end
        MB_FULL: begin
          if (latch_q) begin
            // A simultaneous read consumed the old byte: no data lost.
            state_d = MB_FULL;
            ovr_evt = !rd_q;
          end else if (rd_q) begin
            state_d = MB_EMPTY;
          end else if (tmo_hit) begin
            state_d = MB_EMPTY;
            tmo_evt = 1'b1;
          end
        end
        default: state_d = MB_EMPTY;
      endcase

      // A clear and a coincident event resolve as "cleared, then event".
      ovr_d = ovr_evt | (ovr_q & ~ERR_CLR);
      tmo_d = tmo_evt | (tmo_q & ~ERR_CLR);
      cnt_d = cnt_q;
      if (ERR_CLR) begin
        cnt_d = ovr_evt ? OVR_CNT_W'(1) : '0;
      end else if (ovr_evt && cnt_q != '1) begin
        cnt_d = cnt_q + OVR_CNT_W'(1);
      end
    end

    assign latch_v[c] = latch_q;
    assign full_v[c]  = (state_q == MB_FULL);
    assign ovr_v[c]   = ovr_q;
    assign tmo_v[c]   = tmo_q;
    assign cnt_v[c]   = cnt_q;
  end

  assign ZX_LATCH_EN  = latch_v[0];
  assign FDD_LATCH_EN = latch_v[1];
  assign A_FULL       = full_v[0];
  assign B_FULL       = full_v[1];
  assign A_OVR        = ovr_v[0];
  assign B_OVR        = ovr_v[1];
  assign A_OVR_CNT    = cnt_v[0];
  assign B_OVR_CNT    = cnt_v[1];
  assign A_TMO        = tmo_v[0];
  assign B_TMO        = tmo_v[1];

endmodule

// File: tb/tb_zx_fdd_mailbox_ctrl.sv
// ---------------------------------------------------------------------------
// tb_zx_fdd_mailbox_ctrl
//   Self-checking bench for zx_fdd_mailbox_ctrl. Stimulus tasks update a
//   per-channel mailbox model (full/overrun/timeout bookkeeping) and queue
//   the expected latch pulses and status snapshots with the cycle at which
//   they must appear; an independent monitor compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_zx_fdd_mailbox_ctrl;
  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMO  = 50;

  logic          clk     = 1'b0;
  logic          nreset  = 1'b0;
  logic [3:0]    strb_n  = 4'hF;  // {ZX rd, TIOUT, TIIN, ZX wr}
  logic          err_clr = 1'b0;
  logic          zx_latch_en, fdd_latch_en;
  logic          a_full, b_full, a_ovr, b_ovr, a_tmo, b_tmo;
  logic [CW-1:0] a_ovr_cnt, b_ovr_cnt;
  logic [13:0]   dut_vec;

  always #5 clk = ~clk;

  zx_fdd_mailbox_ctrl #(
    .SYNC_STAGES   (SYNC),
    .OVR_CNT_W     (CW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK_16MHZ   (clk),
    .nRESET      (nreset),
    .nZX_WR_STB  (strb_n[0]),
    .nZX_RD_STB  (strb_n[3]),
    .nTIOUT      (strb_n[2]),
    .nTIIN       (strb_n[1]),
    .ERR_CLR     (err_clr),
    .ZX_LATCH_EN (zx_latch_en),
    .FDD_LATCH_EN(fdd_latch_en),
    .A_FULL      (a_full),
    .B_FULL      (b_full),
    .A_OVR       (a_ovr),
    .B_OVR       (b_ovr),
    .A_OVR_CNT   (a_ovr_cnt),
    .B_OVR_CNT   (b_ovr_cnt),
    .A_TMO       (a_tmo),
    .B_TMO       (b_tmo)
  );

  assign dut_vec = {a_full, b_full, a_ovr, b_ovr, a_tmo, b_tmo, a_ovr_cnt, b_ovr_cnt};

  typedef struct { int cyc; logic [13:0] v; } snap_t;
  typedef struct { int ch; int cyc; } lat_t;

  snap_t stat_q[$];
  lat_t  lat_q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  // Mailbox model: index 0 = channel A, 1 = channel B.
  bit m_full[2];
  bit m_ovr[2];
  bit m_tmo[2];
  int m_cnt[2];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [13:0] model_vec();
    return {m_full[0], m_full[1], m_ovr[0], m_ovr[1], m_tmo[0], m_tmo[1],
            CW'(m_cnt[0]), CW'(m_cnt[1])};
  endfunction

  function automatic void push_snap(input int at);
    stat_q.push_back('{at, model_vec()});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_pulse(input int ch);
    lat_t e;
    if (lat_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL latch_unexpected: channel %0d pulsed at cycle %0d, none expected", ch, cyc);
    end else begin
      e = lat_q.pop_front();
      check("latch_channel", 32'(ch), 32'(e.ch));
      check("latch_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor: consumes expectations independently of the stimulus thread.
  initial forever begin
    snap_t s;
    @(negedge clk);
    if (mon_en) begin
      if (zx_latch_en === 1'b1) check_pulse(0);
      if (fdd_latch_en === 1'b1) check_pulse(1);
      while (lat_q.size() > 0 && lat_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL latch_missing: channel %0d expected at cycle %0d, got no pulse",
                 lat_q[0].ch, lat_q[0].cyc);
        void'(lat_q.pop_front());
      end
      while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
        s = stat_q.pop_front();
        check($sformatf("status@%0d", s.cyc), 32'(dut_vec), 32'(s.v));
      end
    end
  end

  task automatic do_reset(input logic [3:0] hold_low, input int n_idle);
    nreset = 1'b0;
    strb_n = 4'hF & ~hold_low;
    for (int c = 0; c < 2; c++) begin
      m_full[c] = 1'b0; m_ovr[c] = 1'b0; m_tmo[c] = 1'b0; m_cnt[c] = 0;
    end
    for (int i = 1; i <= 3; i++) push_snap(cyc + i);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    for (int i = 1; i <= n_idle; i++) push_snap(cyc + i);
    repeat (n_idle) @(negedge clk);
  endtask

  // Hold the strobes in m low, release them together, optionally pulse
  // ERR_CLR in the cycle the resulting events are applied.
  task automatic do_op(input logic [3:0] m, input int hold, input bit clr_with, output int rel);
    bit w, r, ovr_ev;
    strb_n = strb_n & ~m;
    repeat (hold) @(negedge clk);
    strb_n = 4'hF;
    rel = cyc;
    push_snap(rel + SYNC + 1);
    if (m[0]) lat_q.push_back('{0, rel + SYNC + 1});
    if (m[2]) lat_q.push_back('{1, rel + SYNC + 1});
    for (int c = 0; c < 2; c++) begin
      w = m[2*c];
      r = m[2*c+1];
      ovr_ev = 1'b0;
      if (w) begin
        ovr_ev = m_full[c] && !r;
        m_full[c] = 1'b1;
      end else if (r) begin
        m_full[c] = 1'b0;
      end
      if (clr_with) begin
        m_ovr[c] = ovr_ev;
        m_cnt[c] = ovr_ev ? 1 : 0;
        m_tmo[c] = 1'b0;
      end else if (ovr_ev) begin
        m_ovr[c] = 1'b1;
        if (m_cnt[c] < CMAX) m_cnt[c]++;
      end
    end
    push_snap(rel + SYNC + 2);
    push_snap(rel + SYNC + 5);
    repeat (SYNC + 1) @(negedge clk);
    if (clr_with) err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    for (int c = 0; c < 2; c++) begin
      m_ovr[c] = 1'b0; m_cnt[c] = 0; m_tmo[c] = 1'b0;
    end
    push_snap(cyc + 1);
    push_snap(cyc + 2);
    @(negedge clk);
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int rel;
    int target;
    mon_en = 1'b1;
    @(negedge clk);

    // Reset, then 100 idle cycles with everything at 0.
    do_reset(4'h0, 100);

    // Single ZX write, FDD read, then a read of an empty mailbox.
    do_op(4'b0001, 10, 1'b0, rel);
    do_op(4'b0010, 10, 1'b0, rel);
    do_op(4'b0010, 4, 1'b0, rel);

    // Three writes without a read, then ERR_CLR leaves FULL intact.
    repeat (3) do_op(4'b0001, 10, 1'b0, rel);
    do_clr();

    // Counter saturation on channel B.
    do_reset(4'h0, 5);
    repeat (20) do_op(4'b0100, 2, 1'b0, rel);
    do_clr();

    // Simultaneous write+read: while FULL, then while EMPTY.
    do_reset(4'h0, 5);
    do_op(4'b0001, 10, 1'b0, rel);
    do_op(4'b0011, 10, 1'b0, rel);
    do_op(4'b0010, 3, 1'b0, rel);
    do_op(4'b0011, 3, 1'b0, rel);

    // Two overruns, then an overrun coinciding with ERR_CLR, then ERR_CLR
    // coinciding with a plain read.
    do_op(4'b0001, 2, 1'b0, rel);
    do_op(4'b0001, 2, 1'b0, rel);
    do_op(4'b0101, 2, 1'b1, rel);
    do_op(4'b0110, 2, 1'b1, rel);

    // ZX write strobe held low across reset release.
    do_reset(4'b0001, 5);
    do_op(4'b0001, 10, 1'b0, rel);

    // FULL residency: forced EMPTY after TMO cycles only with the feature.
    do_reset(4'h0, 5);
    do_op(4'b0001, 10, 1'b0, rel);
`ifdef MAILBOX_TIMEOUT_EN
    push_snap(rel + SYNC + 2 + TMO - 1);
    m_full[0] = 1'b0;
    m_tmo[0]  = 1'b1;
    push_snap(rel + SYNC + 2 + TMO);
    target = rel + SYNC + 2 + TMO + 2;
    while (cyc < target) @(negedge clk);
`else
    push_snap(rel + SYNC + 2 + 200);
    target = rel + SYNC + 2 + 202;
    while (cyc < target) @(negedge clk);

    // Randomised mix of writes, reads, collisions and clears.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clr();
      end else begin
        do_op(4'($urandom_range(1, 15)), int'($urandom_range(1, 6)),
              ($urandom_range(0, 7) == 0), rel);
      end
    end
`endif

    repeat (10) @(negedge clk);
    check("latch_queue_drained", 32'(lat_q.size()), 32'd0);
    check("status_queue_drained", 32'(stat_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
